// File: rtl/uart_full_duplex_unit.sv
// Full-duplex 8-bit UART: start, 8 data bits LSB first, parity, stop.
// Independent TX and RX state machines share one clock and reset.
module uart_full_duplex_unit #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_data_clf,
  output logic [7:0] Rx_Data_w,
  output logic       parity_error,
  output logic       in_save_data_bits_w,
  output logic [2:0] Rx_state_out,
  input  logic       tx_send,
  input  logic       tx_send_en,
  input  logic       tx_data_en,
  input  logic [7:0] Tx_Data,
  output logic       tx,
  output logic       tx_send_w,
  output logic [2:0] Tx_state_out
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic PAR_INV = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2,
    RX_PARITY = 3'd3, RX_STOP = 3'd4, RX_SAVE = 3'd5
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2,
    TX_PARITY = 3'd3, TX_STOP = 3'd4
  } tx_state_t;

  // ---------------- Transmitter ----------------
  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [2:0]    tx_idx_nxt;
  logic [7:0]    tx_hold_q, tx_hold_d;
  logic          tx_q, tx_d;

  // TX state register, bit timer, holding register and registered pin
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_hold_q  <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_hold_q  <= tx_hold_d;
      tx_q       <= tx_d;
    end
  end

  // TX next state; the pin value is computed for the state being entered so
  // that tx changes on the same edge as Tx_state_out.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_hold_d  = tx_hold_q;
    tx_d       = tx_q;
    tx_idx_nxt = tx_idx_q + 3'd1;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (tx_data_en) tx_hold_d = Tx_Data;
        if (tx_send && tx_send_en) begin
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_state_d = TX_DATA;
          tx_d       = tx_hold_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_state_d = TX_PARITY;
            tx_d       = (^tx_hold_q) ^ PAR_INV;
          end else begin
            tx_idx_d = tx_idx_nxt;
            tx_d     = tx_hold_q[tx_idx_nxt];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_PARITY: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
          tx_d       = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  assign tx           = tx_q;
  assign tx_send_w    = (tx_state_q == TX_STOP);
  assign Tx_state_out = tx_state_q;

  // ---------------- Receiver ----------------
  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_par_q, rx_par_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_perr_q, rx_perr_d;
  logic          rx_meta_q, rx_meta_d;
  logic          rx_sync_q, rx_sync_d;

  // RX synchronizer, state register, sampling timer and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_data_q  <= rx_data_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  // RX next state; the clear request is applied first so SAVE overrides it.
  always_comb begin
    rx_meta_d  = rx;
    rx_sync_d  = rx_meta_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    if (rx_data_clf) begin
      rx_data_d = '0;
      rx_perr_d = 1'b0;
    end
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) rx_state_d = RX_PARITY;
          else                  rx_idx_d   = rx_idx_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_PARITY: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_sync_q;
          rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_SAVE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_SAVE: begin
        rx_data_d  = rx_shift_q;
        rx_perr_d  = rx_par_q != ((^rx_shift_q) ^ PAR_INV);
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign Rx_Data_w           = rx_data_q;
  assign parity_error        = rx_perr_q;
  assign in_save_data_bits_w = (rx_state_q == RX_SAVE);
  assign Rx_state_out        = rx_state_q;

endmodule

// File: tb/tb_uart_full_duplex_unit.sv
// Directed bench for uart_full_duplex_unit (CLKS_PER_BIT=16, even parity).
module tb_uart_full_duplex_unit;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx;
  logic       rx_data_clf = 1'b0;
  logic [7:0] Rx_Data_w;
  logic       parity_error;
  logic       in_save_data_bits_w;
  logic [2:0] Rx_state_out;
  logic       tx_send = 1'b0;
  logic       tx_send_en = 1'b0;
  logic       tx_data_en = 1'b0;
  logic [7:0] Tx_Data = 8'h00;
  logic       tx;
  logic       tx_send_w;
  logic [2:0] Tx_state_out;

  logic loop_en = 1'b0;
  logic rx_bb   = 1'b1;
  assign rx = loop_en ? tx : rx_bb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_full_duplex_unit #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rx                  (rx),
    .rx_data_clf         (rx_data_clf),
    .Rx_Data_w           (Rx_Data_w),
    .parity_error        (parity_error),
    .in_save_data_bits_w (in_save_data_bits_w),
    .Rx_state_out        (Rx_state_out),
    .tx_send             (tx_send),
    .tx_send_en          (tx_send_en),
    .tx_data_en          (tx_data_en),
    .Tx_Data             (Tx_Data),
    .tx                  (tx),
    .tx_send_w           (tx_send_w),
    .Tx_state_out        (Tx_state_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one serial frame on rx_bb, one bit per CPB cycles.
  task automatic send_rx_frame(input logic [7:0] d, input logic par);
    logic [10:0] bits;
    bits = {1'b1, par, d, 1'b0};
    for (int b = 0; b < 11; b++) begin
      rx_bb = bits[b];
      repeat (CPB) @(negedge clk);
    end
    rx_bb = 1'b1;
  endtask

  // Present a one-cycle send request; returns at the negedge after the accepting edge.
  task automatic tx_request(input logic [7:0] d);
    @(negedge clk);
    Tx_Data    = d;
    tx_data_en = 1'b1;
    tx_send    = 1'b1;
    tx_send_en = 1'b1;
    @(negedge clk);
    tx_data_en = 1'b0;
    tx_send    = 1'b0;
    tx_send_en = 1'b0;
  endtask

  initial begin
    logic [10:0] exp_bits;
    int sendw_cnt;
    int save_cnt;
    int bad_cnt;
    logic saw_start;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_tx_state", Tx_state_out, 0);
    check("rst_rx_state", Rx_state_out, 0);
    check("rst_rx_data", Rx_Data_w, 0);
    check("rst_perr", parity_error, 0);
    check("rst_save", in_save_data_bits_w, 0);
    check("rst_send_w", tx_send_w, 0);

    // Loopback 0xA5: stop, parity 0, data LSB first, start
    loop_en  = 1'b1;
    exp_bits = 11'b1_0_10100101_0;
    tx_request(8'hA5);
    check("lb_start_state", Tx_state_out, 1);
    check("lb_start_tx", tx, 0);
    sendw_cnt = 0;
    save_cnt  = 0;
    for (int i = 0; i < 11 * CPB + 40; i++) begin
      if (i > 0) @(negedge clk);
      if (tx_send_w) sendw_cnt++;
      if (in_save_data_bits_w) save_cnt++;
      if ((i % CPB) == CPB / 2 && (i / CPB) < 11)
        check($sformatf("lb_bit%0d", i / CPB), tx, exp_bits[i / CPB]);
      if (i == 11 * CPB - 1) check("lb_last_stop", Tx_state_out, 4);
      if (i == 11 * CPB)     check("lb_back_idle", Tx_state_out, 0);
    end
    check("lb_rx_data", Rx_Data_w, 8'hA5);
    check("lb_perr", parity_error, 0);
    check("lb_save_pulses", save_cnt, 1);
    check("lb_send_w_cycles", sendw_cnt, CPB);
    loop_en = 1'b0;

    // Bit-banged 0x3C with wrong parity (correct even parity would be 0)
    repeat (4) @(negedge clk);
    send_rx_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    check("bb_rx_data", Rx_Data_w, 8'h3C);
    check("bb_perr", parity_error, 1);

    // Short low glitch on rx must be rejected
    saw_start = 1'b0;
    save_cnt  = 0;
    rx_bb = 1'b0;
    repeat (3) @(negedge clk);
    rx_bb = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (Rx_state_out == 3'd1) saw_start = 1'b1;
      if (in_save_data_bits_w) save_cnt++;
    end
    check("gl_saw_start", saw_start, 1);
    check("gl_back_idle", Rx_state_out, 0);
    check("gl_no_save", save_cnt, 0);
    check("gl_data_kept", Rx_Data_w, 8'h3C);
    check("gl_perr_kept", parity_error, 1);

    // Clear
    rx_data_clf = 1'b1;
    @(negedge clk);
    rx_data_clf = 1'b0;
    check("clf_data", Rx_Data_w, 0);
    check("clf_perr", parity_error, 0);

    // Request without enable is ignored
    bad_cnt    = 0;
    tx_send    = 1'b1;
    tx_send_en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || Tx_state_out !== 3'd0) bad_cnt++;
    end
    tx_send = 1'b0;
    check("noen_violations", bad_cnt, 0);

    // Reset mid-DATA during 0xFF loopback, then receive 0x12
    loop_en = 1'b1;
    tx_request(8'hFF);
    repeat (CPB + 40) @(negedge clk);
    check("mid_in_data", Tx_state_out, 2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", tx, 1);
    check("mid_rst_tx_state", Tx_state_out, 0);
    check("mid_rst_rx_state", Rx_state_out, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    save_cnt = 0;
    tx_request(8'h12);
    for (int i = 0; i < 11 * CPB + 40; i++) begin
      @(negedge clk);
      if (in_save_data_bits_w) save_cnt++;
    end
    check("post_rx_data", Rx_Data_w, 8'h12);
    check("post_perr", parity_error, 0);
    check("post_save_pulses", save_cnt, 1);
    check("post_tx_idle", Tx_state_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_full_duplex_unit.md
# uart_full_duplex_unit

Full-duplex 8-bit UART: one transmitter and one receiver sharing a clock and reset, each with its own FSM. Frame format is 8N+parity: start bit, 8 data bits LSB first, one parity bit, one stop bit. The block sits between the RISC-V pipeline's memory-mapped UART registers and the serial pins. It exports both FSM states for debug and for system-level observation.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per serial bit; must be even and ≥ 4.
- PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.

- clk  in  1  single system clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- rx  in  1  serial input; idles high.
- rx_data_clf  in  1  clears Rx_Data_w and parity_error.
- Rx_Data_w  out  8  last received byte.
- parity_error  out  1  parity mismatch on the last received byte.
- in_save_data_bits_w  out  1  high for exactly the one cycle the receiver spends in SAVE.
- Rx_state_out  out  3  receiver state (rx_state_t).
- tx_send  in  1  transmit request.
- tx_send_en  in  1  gates tx_send.
- tx_data_en  in  1  load enable for Tx_Data.
- Tx_Data  in  8  byte to transmit.
- tx  out  1  serial output; idles high.
- tx_send_w  out  1  high while the transmitter is in STOP.
- Tx_state_out  out  3  transmitter state (tx_state_t).

## Operation
- rx_state_t encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, SAVE=5.
- tx_state_t encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
- Reset values:
  - Both FSMs return to IDLE.
  - tx=1.
  - Rx_Data_w=0, parity_error=0, in_save_data_bits_w=0, tx_send_w=0.
  - All counters and shift registers are cleared.
  - Reset mid-frame aborts the frame immediately.
- Transmitter holding register:
  - Loads Tx_Data when tx_data_en=1 and Tx state is IDLE.
  - Is not loaded while a frame is in progress.
- Transmitter start:
  - In IDLE, tx_send & tx_send_en starts a frame.
  - The frame uses the holding register. If tx_data_en is also high in that cycle, it uses Tx_Data directly.
  - tx_send=1 with tx_send_en=0 is ignored.
- Transmitter sequence:
  - START: tx=0.
  - DATA: bits 0 to 7.
  - PARITY: XOR of the data bits (inverted when PARITY_ODD=1).
  - STOP: tx=1.
  - Then back to IDLE.
  - Each state/bit lasts CLKS_PER_BIT cycles.
- Transmitter back-to-back: a tx_send still held high when the FSM returns to IDLE starts the next frame.
- Receiver input: rx passes through a 2-flop synchronizer before use.
- Receiver IDLE: a synchronized low moves the FSM to START.
- Receiver START:
  - After CLKS_PER_BIT/2 cycles, rx is resampled.
  - Low moves to DATA.
  - High is treated as a glitch and the FSM returns to IDLE with no other effect.
- Receiver DATA: samples a bit every CLKS_PER_BIT cycles, at mid-bit; 8 samples, shifted in LSB first.
- Receiver PARITY: samples the parity bit at mid-bit.
- Receiver STOP:
  - Samples at mid-bit, then moves to SAVE.
  - A low stop bit is not flagged; the frame is still saved.
- Receiver SAVE (one cycle):
  - Rx_Data_w is loaded with the shifted byte.
  - parity_error is set to 1 when the received parity differs from the computed parity, else 0.
  - in_save_data_bits_w=1.
  - The FSM then moves to IDLE.
- rx_data_clf: forces Rx_Data_w=0 and parity_error=0 on the next edge. SAVE takes priority when both occur in the same cycle.
- Full duplex: the TX and RX paths are fully independent; simultaneous operation is legal.

## Timing
- TX:
  - A request accepted at edge n gives Tx_state_out=START and tx=0 from edge n+1.
  - The frame lasts 11×CLKS_PER_BIT cycles.
  - IDLE at edge n+1+11×CLKS_PER_BIT.
- tx_send_w is high for exactly CLKS_PER_BIT cycles per frame.
- RX:
  - The SAVE pulse occurs 10.5×CLKS_PER_BIT + 3 (±1) cycles after the start-bit falling edge at the pin.
  - The receiver is back in IDLE before the stop bit ends, so back-to-back frames are received without loss.

## Test plan
- Reset check: hold rst=1 for 2 cycles, release.
  - Required: tx=1, both states IDLE, Rx_Data_w=0, parity_error=0, in_save_data_bits_w=0, tx_send_w=0.
- Loopback (tx wired to rx): Tx_Data=0xA5, tx_data_en=1, one-cycle tx_send=tx_send_en=1.
  - Required tx sequence: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1.
  - Required receive: Rx_Data_w=0xA5, parity_error=0, one in_save_data_bits_w pulse.
  - Required: tx_send_w high for 16 cycles.
- Bit-banged 0x3C with a wrong parity bit on rx.
  - Required: Rx_Data_w=0x3C, parity_error=1.
  - Then rx_data_clf=1 for one cycle gives Rx_Data_w=0x00, parity_error=0.
- tx_send=1 with tx_send_en=0 for 100 cycles.
  - Required: tx stays 1 and Tx_state_out stays IDLE.
- A 3-cycle low glitch on rx.
  - Required: Rx_state_out goes IDLE→START→IDLE; no SAVE pulse; Rx_Data_w unchanged.
- Reset asserted mid-DATA during a 0xFF transmission.
  - Required: tx=1 and both FSMs IDLE on the next edge.
  - Required: a following 0x12 frame is received correctly.
